// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - shared types, constants and helpers for timer_sched
package timer_sched_pkg;

   typedef enum logic {SCAN, RELOAD} sched_state_e;

   localparam logic [31:0] TIM_DELAY_MAX = 32'h7FFF_FFFF;

   function automatic logic [31:0] clamp_delay(input logic [31:0] delay);
      if (delay == 32'd0) return 32'd1;
      if (delay[31]) return TIM_DELAY_MAX;
      return delay;
   endfunction

   // A deadline up to 2^31-1 ticks behind now still counts as reached, across the wrap.
   function automatic logic expired(input logic [31:0] now, input logic [31:0] deadline);
      logic [31:0] diff;
      diff = now - deadline;
      return ~diff[31];
   endfunction

endpackage

// File: rtl/timer_sched_if.sv
// rtl/timer_sched_if.sv - arm/cancel request bundle between the register wrapper and timer_sched
interface timer_sched_if #(
   parameter int CH_NUM = 4,
   parameter int CH_W   = $clog2(CH_NUM)
);
   logic            arm_valid_i;
   logic            arm_ready_o;
   logic [CH_W-1:0] arm_ch_i;
   logic [31:0]     arm_delay_i;
   logic            arm_periodic_i;
   logic            cancel_valid_i;
   logic [CH_W-1:0] cancel_ch_i;

   modport master (
      output arm_valid_i, arm_ch_i, arm_delay_i, arm_periodic_i, cancel_valid_i, cancel_ch_i,
      input  arm_ready_o
   );

   modport slave (
      input  arm_valid_i, arm_ch_i, arm_delay_i, arm_periodic_i, cancel_valid_i, cancel_ch_i,
      output arm_ready_o
   );
endinterface

// File: rtl/timer_sched_slot.sv
// rtl/timer_sched_slot.sv - per-channel timer state; overrun counter when TIMER_SCHED_OVR_EN is defined
module timer_sched_slot (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        arm,
   input  logic [31:0] arm_deadline,
   input  logic [31:0] arm_period,
   input  logic        arm_periodic,
   input  logic        cancel,
   input  logic        fire,
   input  logic        reload,
   input  logic        ack,
   output logic [31:0] deadline,
   output logic        periodic,
   output logic        active,
   output logic        pend
`ifdef TIMER_SCHED_OVR_EN
   ,
   output logic [7:0]  ovr
`endif
);

   logic [31:0] period;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         deadline <= '0;
         period   <= '0;
         periodic <= 1'b0;
         active   <= 1'b0;
         pend     <= 1'b0;
      end else begin
         if (arm) begin
            deadline <= arm_deadline;
            period   <= arm_period;
            periodic <= arm_periodic;
         end else if (reload) begin
            deadline <= deadline + period;
         end

         // Arm beats cancel and one-shot expiry; a reload still completes after a cancel.
         if (arm)
            active <= 1'b1;
         else if (cancel || (fire && !periodic))
            active <= 1'b0;

         pend <= (pend & ~ack) | fire;
      end
   end

`ifdef TIMER_SCHED_OVR_EN
   always_ff @(posedge clk_i) begin
      if (rst_i)
         ovr <= '0;
      else if (ack)
         ovr <= '0;
      else if (fire && pend && (ovr != 8'hFF))
         ovr <= ovr + 8'd1;
   end
`endif

endmodule

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - shared-timebase multi-channel timer scheduler with round-robin expiry scan
// Optional per-channel overrun counters (ovr_o) when TIMER_SCHED_OVR_EN is defined.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int CH_NUM = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              tick_i,
   timer_sched_if.slave      arm_if,
   input  logic [CH_NUM-1:0] ack_i,
   output logic [CH_NUM-1:0] pend_o,
   output logic [CH_NUM-1:0] active_o,
   output logic              irq_o,
   output logic [31:0]       now_o
`ifdef TIMER_SCHED_OVR_EN
   ,
   output logic [CH_NUM*8-1:0] ovr_o
`endif
);

   localparam int CH_W = $clog2(CH_NUM);

   sched_state_e    state_q, state_d;
   logic [CH_W-1:0] ptr_q, ptr_d, ptr_next;
   logic [31:0]     now_q;

   logic [31:0]       deadline [CH_NUM];
   logic [CH_NUM-1:0] periodic, active, pend;
   logic [CH_NUM-1:0] arm_dec, cancel_dec, fire_dec, reload_dec;

   logic        arm_fire, cur_fire, cur_arm_hit;
   logic [31:0] arm_delay_c, arm_deadline;

   // Deadline storage has a single write port, so arms are held off during RELOAD.
   assign arm_if.arm_ready_o = (state_q == SCAN) && !rst_i;
   assign arm_fire           = arm_if.arm_valid_i && arm_if.arm_ready_o;
   assign arm_delay_c        = clamp_delay(arm_if.arm_delay_i);
   assign arm_deadline       = now_q + arm_delay_c;
   assign cur_arm_hit        = arm_fire && (arm_if.arm_ch_i == ptr_q);
   assign ptr_next           = (ptr_q == CH_W'(CH_NUM - 1)) ? '0 : ptr_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         now_q <= '0;
      else if (tick_i)
         now_q <= now_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SCAN;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cur_fire = 1'b0;
      case (state_q)
         SCAN: begin
            cur_fire = active[ptr_q] && expired(now_q, deadline[ptr_q]);
            // A same-cycle arm replaces the deadline, so the reload must not be applied on top.
            if (cur_fire && periodic[ptr_q] && !cur_arm_hit)
               state_d = RELOAD;
            else
               ptr_d = ptr_next;
         end
         RELOAD: begin
            state_d = SCAN;
            ptr_d   = ptr_next;
         end
         default: state_d = SCAN;
      endcase
   end

   // Indices >= CH_NUM match no slot, so such requests are accepted and dropped.
   always_comb begin
      arm_dec    = '0;
      cancel_dec = '0;
      fire_dec   = '0;
      reload_dec = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         arm_dec[i]    = arm_fire && (arm_if.arm_ch_i == CH_W'(i));
         cancel_dec[i] = arm_if.cancel_valid_i && (arm_if.cancel_ch_i == CH_W'(i));
         fire_dec[i]   = cur_fire && (ptr_q == CH_W'(i));
         reload_dec[i] = (state_q == RELOAD) && (ptr_q == CH_W'(i));
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_slot
      timer_sched_slot u_slot (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .arm          (arm_dec[g]),
         .arm_deadline (arm_deadline),
         .arm_period   (arm_delay_c),
         .arm_periodic (arm_if.arm_periodic_i),
         .cancel       (cancel_dec[g]),
         .fire         (fire_dec[g]),
         .reload       (reload_dec[g]),
         .ack          (ack_i[g]),
         .deadline     (deadline[g]),
         .periodic     (periodic[g]),
         .active       (active[g]),
         .pend         (pend[g])
`ifdef TIMER_SCHED_OVR_EN
         ,
         .ovr          (ovr_o[g*8 +: 8])
`endif
      );
   end

   assign pend_o   = pend;
   assign active_o = active;
   assign irq_o    = |pend;
   assign now_o    = now_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - self-checking bench for timer_sched against a tick-level reference model
module tb_timer_sched;

   localparam int CH_NUM = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              tick = 1'b0;
   logic [CH_NUM-1:0] ack = '0;
   logic [CH_NUM-1:0] pend, active;
   logic              irq;
   logic [31:0]       now;
`ifdef TIMER_SCHED_OVR_EN
   logic [CH_NUM*8-1:0] ovr;
`endif

   timer_sched_if #(.CH_NUM(CH_NUM)) sif ();

   timer_sched #(.CH_NUM(CH_NUM)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .tick_i   (tick),
      .arm_if   (sif.slave),
      .ack_i    (ack),
      .pend_o   (pend),
      .active_o (active),
      .irq_o    (irq),
      .now_o    (now)
`ifdef TIMER_SCHED_OVR_EN
      ,
      .ovr_o    (ovr)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: timer state advanced once per tick from the arm/expire rules.
   logic [31:0]       m_now;
   logic [31:0]       m_dl  [CH_NUM];
   logic [31:0]       m_per [CH_NUM];
   int                m_ovr [CH_NUM];
   logic [CH_NUM-1:0] m_perd, m_act, m_pend;

   function automatic void model_reset();
      m_now = 0; m_perd = '0; m_act = '0; m_pend = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         m_dl[i] = 0; m_per[i] = 0; m_ovr[i] = 0;
      end
   endfunction

   function automatic void model_arm(input int ch, input logic [31:0] delay, input logic per);
      logic [31:0] d;
      d = (delay == 0) ? 32'd1 : (delay >= 32'h8000_0000) ? 32'h7FFF_FFFF : delay;
      m_dl[ch] = m_now + d; m_per[ch] = d; m_perd[ch] = per; m_act[ch] = 1'b1;
   endfunction

   function automatic int model_tick();
      int reloads = 0;
      m_now = m_now + 32'd1;
      for (int i = 0; i < CH_NUM; i++) begin
         if (m_act[i] && $signed(m_now - m_dl[i]) >= 0) begin
            if (m_pend[i] && m_ovr[i] < 255) m_ovr[i]++;
            m_pend[i] = 1'b1;
            if (m_perd[i]) begin
               m_dl[i] = m_dl[i] + m_per[i];
               reloads++;
            end else begin
               m_act[i] = 1'b0;
            end
         end
      end
      return reloads;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":pend"}, 32'(pend), 32'(m_pend));
      chk({tag, ":active"}, 32'(active), 32'(m_act));
      chk({tag, ":irq"}, 32'(irq), 32'(|m_pend));
      chk({tag, ":now"}, now, m_now);
`ifdef TIMER_SCHED_OVR_EN
      for (int i = 0; i < CH_NUM; i++)
         chk({tag, ":ovr"}, 32'(ovr[i*8 +: 8]), 32'(m_ovr[i]));
`endif
   endtask

   task automatic do_arm(input int ch, input logic [31:0] delay, input logic per, input logic with_cancel);
      int n = 0;
      @(negedge clk);
      sif.arm_valid_i = 1'b1; sif.arm_ch_i = 2'(ch); sif.arm_delay_i = delay; sif.arm_periodic_i = per;
      sif.cancel_valid_i = with_cancel; sif.cancel_ch_i = 2'(ch);
      while (!sif.arm_ready_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("arm_accept", 32'(sif.arm_ready_o), 32'd1);
      @(negedge clk);
      sif.arm_valid_i = 1'b0; sif.cancel_valid_i = 1'b0;
      model_arm(ch, delay, per);
   endtask

   task automatic do_cancel(input int ch);
      @(negedge clk);
      sif.cancel_valid_i = 1'b1; sif.cancel_ch_i = 2'(ch);
      @(negedge clk);
      sif.cancel_valid_i = 1'b0;
      m_act[ch] = 1'b0;
   endtask

   task automatic do_ack(input logic [CH_NUM-1:0] mask);
      @(negedge clk);
      ack = mask;
      @(negedge clk);
      ack = '0;
      m_pend = m_pend & ~mask;
      for (int i = 0; i < CH_NUM; i++) if (mask[i]) m_ovr[i] = 0;
   endtask

   // One tick, then let the scan settle while counting cycles with arm_ready low.
   task automatic tick_and_check(input string tag);
      int exp_rl, low;
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      exp_rl = model_tick();
      low = sif.arm_ready_o ? 0 : 1;
      repeat (10) begin
         @(negedge clk);
         if (!sif.arm_ready_o) low++;
      end
      chk({tag, ":reload_cycles"}, 32'(low), 32'(exp_rl));
      check_all(tag);
   endtask

   // One tick; all channels in mask must show pend within CH_NUM+1 edges.
   task automatic tick_latency(input string tag, input logic [CH_NUM-1:0] mask);
      int lat = 0;
      void'(model_tick());
      @(negedge clk) tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
      for (int k = 1; k <= CH_NUM + 1; k++) begin
         @(posedge clk);
         #1;
         if ((pend & mask) == mask) begin
            lat = k;
            break;
         end
      end
      chk({tag, ":in_time"}, 32'(lat != 0), 32'd1);
      repeat (6) @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sif.arm_valid_i = 1'b0; sif.arm_ch_i = '0; sif.arm_delay_i = '0; sif.arm_periodic_i = 1'b0;
      sif.cancel_valid_i = 1'b0; sif.cancel_ch_i = '0;
      model_reset();

      // Reset
      repeat (3) @(negedge clk);
      chk("ready_in_reset", 32'(sif.arm_ready_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(sif.arm_ready_o), 32'd1);
      check_all("reset");

      // One-shot ch0 delay 5
      do_arm(0, 5, 1'b0, 1'b0);
      for (int t = 1; t <= 4; t++) tick_and_check("oneshot_early");
      tick_latency("oneshot_fire", 4'b0001);
      do_ack(4'b0001);
      check_all("oneshot_ack");

      // Periodic ch1 delay 3: no drift, one RELOAD cycle per expiry
      do_arm(1, 3, 1'b1, 1'b0);
      for (int t = 1; t <= 15; t++) begin
         tick_and_check("periodic");
         if (m_pend != 0) do_ack(m_pend);
      end
      do_cancel(1);
      check_all("periodic_cancel");

      // Timebase wrap: deadline 2 armed at 0xFFFF_FFFE
      @(negedge clk);
      force dut.now_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.now_q;
      m_now = 32'hFFFF_FFFE;
      check_all("wrap_set");
      do_arm(2, 4, 1'b0, 1'b0);
      for (int t = 1; t <= 4; t++) tick_and_check("wrap");
      chk("wrap_fired", 32'(pend[2]), 32'd1);
      do_ack(4'b0100);

      // Cancel mid-flight, then arm+cancel in the same cycle
      do_arm(3, 100, 1'b0, 1'b0);
      for (int t = 1; t <= 50; t++) tick_and_check("cancel_pre");
      do_cancel(3);
      for (int t = 51; t <= 200; t++) tick_and_check("cancel_post");
      do_arm(3, 100, 1'b0, 1'b1);
      check_all("arm_beats_cancel");
      do_cancel(3);

      // Clamp: huge delay never expires soon; zero delay fires next tick
      do_arm(0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_arm(1, 0, 1'b0, 1'b0);
      for (int t = 1; t <= 3; t++) tick_and_check("clamp");
      do_cancel(0);
      do_ack(m_pend);

      // All channels on one tick
      for (int c = 0; c < CH_NUM; c++) do_arm(c, 1, 1'b0, 1'b0);
      tick_latency("all_fire", 4'b1111);
      for (int c = 0; c < CH_NUM; c++) begin
         do_ack(4'(1 << c));
         check_all("all_ack");
      end

      // Randomized traffic
      for (int it = 0; it < 60; it++) begin
         int op, ch;
         logic [31:0] d;
         op = $urandom_range(0, 3);
         ch = $urandom_range(0, CH_NUM - 1);
         d  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 6));
         case (op)
            0: do_arm(ch, d, 1'($urandom_range(0, 1)), 1'b0);
            1: do_cancel(ch);
            2: do_ack(4'($urandom_range(0, 15)));
            default: ;
         endcase
         tick_and_check("random");
      end
      for (int c = 0; c < CH_NUM; c++) do_cancel(c);
      do_ack(4'b1111);
      check_all("random_end");

`ifdef TIMER_SCHED_OVR_EN
      // Overrun counter saturation and clear
      do_arm(0, 1, 1'b1, 1'b0);
      for (int t = 1; t <= 300; t++) tick_and_check("ovr");
      chk("ovr_saturated", 32'(ovr[7:0]), 32'd255);
      do_ack(4'b0001);
      check_all("ovr_ack");
      do_cancel(0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
